// File: rtl/captura_operandos.sv
// captura_operandos: loads operand A then operand B from a shared switch bus on debounced button presses.
// Latency: capture occurs SYNC_STAGES+DEB_CYCLES+1 clocks after the raw button settles high.
// Backpressure: none; a synchronized clear wins over a press and holds the loader idle while high.
module captura_operandos #(
    parameter int WIDTH       = 8,
    parameter int DEB_CYCLES  = 250000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn,
    input  logic             clr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             ops_valid,
    output logic             new_pair,
    output logic [1:0]       state
);

    // DEB_CYCLES >= 2, so the counter only needs to reach DEB_CYCLES-1.
    localparam int            CW      = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        READY  = 2'b10,
        BAD    = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic                   btn_s;
    logic                   clr_s;
    logic [CW-1:0]          cnt;
    logic                   deb;
    logic                   deb_d;
    logic                   press;
    state_t                 st;

    assign btn_s = btn_sync[SYNC_STAGES-1];
    assign clr_s = clr_sync[SYNC_STAGES-1];

    // A press is the single cycle where the debounced level has just gone high.
    assign press = deb & ~deb_d;

    assign state = st;

    // Bring the raw asynchronous buttons into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= '0;
            clr_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], clr};
        end
    end

    // Accept a new button level only after it has differed from the current one for DEB_CYCLES edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
        end else begin
            deb_d <= deb;
            if (btn_s == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= btn_s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Operand capture sequencer; clear overrides any press in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= WAIT_A;
            a         <= '0;
            b         <= '0;
            ops_valid <= 1'b0;
            new_pair  <= 1'b0;
        end else begin
            new_pair <= 1'b0;
            if (clr_s) begin
                st        <= WAIT_A;
                a         <= '0;
                b         <= '0;
                ops_valid <= 1'b0;
            end else begin
                case (st)
                    WAIT_A: begin
                        if (press) begin
                            a  <= sw;
                            st <= WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (press) begin
                            b         <= sw;
                            ops_valid <= 1'b1;
                            new_pair  <= 1'b1;
                            st        <= READY;
                        end
                    end
                    READY: begin
                        // Start a new pair: B keeps its old value until it is recaptured.
                        if (press) begin
                            a         <= sw;
                            ops_valid <= 1'b0;
                            st        <= WAIT_B;
                        end
                    end
                    default: begin
                        st        <= WAIT_A;
                        a         <= '0;
                        b         <= '0;
                        ops_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_captura_operandos.sv
// tb_captura_operandos: randomized and directed stimulus against a queue-based reference of the operand loader.
// Latency: bench parameters give capture 7 edges after the button rises.
// Backpressure: not applicable; clear and button are driven freely.
module tb_captura_operandos;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sw;
    logic             btn;
    logic             clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ops_valid;
    logic             new_pair;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    captura_operandos #(
        .WIDTH      (WIDTH),
        .DEB_CYCLES (DEB),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn      (btn),
        .clr      (clr),
        .a        (a),
        .b        (b),
        .ops_valid(ops_valid),
        .new_pair (new_pair),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Reference: sample pipes as queues, debounce as "last DEB synchronized samples all differ".
    bit             mq_btn[$];
    bit             mq_clr[$];
    bit             mwin[$];
    bit             m_deb;
    bit             m_deb_d;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic           m_ov;
    logic           m_np;
    logic [1:0]     m_st;

    function automatic void model_reset();
        mq_btn.delete();
        mq_clr.delete();
        mwin.delete();
        for (int i = 0; i < SYNC; i++) begin
            mq_btn.push_back(1'b0);
            mq_clr.push_back(1'b0);
        end
        for (int i = 0; i < DEB; i++) mwin.push_back(1'b0);
        m_deb   = 1'b0;
        m_deb_d = 1'b0;
        m_a     = '0;
        m_b     = '0;
        m_ov    = 1'b0;
        m_np    = 1'b0;
        m_st    = 2'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        bit bs;
        bit cs;
        bit pr;
        bit all_diff;
        if (!rst_n) begin
            model_reset();
        end else begin
            bs = mq_btn.pop_front();
            mq_btn.push_back(btn);
            cs = mq_clr.pop_front();
            mq_clr.push_back(clr);
            pr = m_deb && !m_deb_d;
            void'(mwin.pop_front());
            mwin.push_back(bs);
            all_diff = 1'b1;
            foreach (mwin[i]) if (mwin[i] == m_deb) all_diff = 1'b0;
            m_deb_d = m_deb;
            if (all_diff) m_deb = !m_deb;
            m_np = 1'b0;
            if (cs) begin
                m_st = 2'd0; m_a = '0; m_b = '0; m_ov = 1'b0;
            end else if (pr) begin
                if (m_st == 2'd0) begin
                    m_a = sw; m_st = 2'd1;
                end else if (m_st == 2'd1) begin
                    m_b = sw; m_ov = 1'b1; m_np = 1'b1; m_st = 2'd2;
                end else begin
                    m_a = sw; m_ov = 1'b0; m_st = 2'd1;
                end
            end
        end
    end

    // Stimulus helper: hold the button high for 'hold' cycles, then let it settle low.
    task automatic do_press(input logic [WIDTH-1:0] v, input int hold);
        @(negedge clk);
        sw  = v;
        btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({a, b, ops_valid, new_pair, state} !== {8'h00, 8'h00, 1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_initial: got a=%h b=%h ov=%b np=%b st=%b, want all zero", a, b, ops_valid, new_pair, state);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({a, b, ops_valid, new_pair, state} !== {m_a, m_b, m_ov, m_np, m_st}) begin
            errors++;
            $display("FAIL reset_release: got a=%h b=%h ov=%b st=%b, want a=%h b=%h ov=%b st=%b", a, b, ops_valid, state, m_a, m_b, m_ov, m_st);
        end
    endtask

    task automatic test_pair_load();
        @(negedge clk);
        sw  = 8'h3C;
        btn = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (a !== 8'h00 || state !== 2'b00) begin
            errors++;
            $display("FAIL pair_a_early: after edge 6 got a=%h st=%b, want a=00 st=00", a, state);
        end
        @(negedge clk);
        checks++;
        if (a !== 8'h3C || state !== 2'b01 || ops_valid !== 1'b0) begin
            errors++;
            $display("FAIL pair_a_capture: after edge 7 got a=%h st=%b ov=%b, want a=3c st=01 ov=0", a, state, ops_valid);
        end
        sw  = 8'hFF;
        btn = 1'b0;
        repeat (12) @(negedge clk);
        sw  = 8'hC3;
        btn = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (b !== 8'h00 || ops_valid !== 1'b0 || new_pair !== 1'b0) begin
            errors++;
            $display("FAIL pair_b_early: got b=%h ov=%b np=%b, want b=00 ov=0 np=0", b, ops_valid, new_pair);
        end
        @(negedge clk);
        checks++;
        if ({a, b, ops_valid, new_pair, state} !== {8'h3C, 8'hC3, 1'b1, 1'b1, 2'b10}) begin
            errors++;
            $display("FAIL pair_b_capture: got a=%h b=%h ov=%b np=%b st=%b, want a=3c b=c3 ov=1 np=1 st=10", a, b, ops_valid, new_pair, state);
        end
        @(negedge clk);
        checks++;
        if (new_pair !== 1'b0 || ops_valid !== 1'b1) begin
            errors++;
            $display("FAIL pair_np_pulse: got np=%b ov=%b, want np=0 ov=1", new_pair, ops_valid);
        end
        btn = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if ({a, b, ops_valid, new_pair, state} !== {m_a, m_b, m_ov, m_np, m_st}) begin
            errors++;
            $display("FAIL pair_model: got a=%h b=%h ov=%b st=%b, want a=%h b=%h ov=%b st=%b", a, b, ops_valid, state, m_a, m_b, m_ov, m_st);
        end
    endtask

    task automatic test_reload();
        do_press(8'h01, 10);
        checks++;
        if ({a, b, ops_valid, state} !== {8'h01, 8'hC3, 1'b0, 2'b01}) begin
            errors++;
            $display("FAIL reload: got a=%h b=%h ov=%b st=%b, want a=01 b=c3 ov=0 st=01", a, b, ops_valid, state);
        end
    endtask

    task automatic test_clear_vs_press();
        @(negedge clk);
        sw  = 8'hEE;
        btn = 1'b1;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 2'b01 || a !== 8'h01) begin
            errors++;
            $display("FAIL clear_early: after edge 6 got st=%b a=%h, want st=01 a=01", state, a);
        end
        @(negedge clk);
        checks++;
        if ({a, b, ops_valid, new_pair, state} !== {8'h00, 8'h00, 1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL clear_wins: got a=%h b=%h ov=%b np=%b st=%b, want all zero", a, b, ops_valid, new_pair, state);
        end
        clr = 1'b0;
        @(negedge clk);
        btn = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (a !== 8'h00 || b !== 8'h00 || state !== 2'b00) begin
            errors++;
            $display("FAIL clear_no_late_capture: got a=%h b=%h st=%b, want a=00 b=00 st=00", a, b, state);
        end
    endtask

    task automatic test_bounce();
        @(negedge clk);
        sw = 8'hA7;
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1;
            repeat (2) @(negedge clk);
            btn = 1'b0;
            repeat (2) @(negedge clk);
            checks++;
            if (state !== 2'b00 || a !== 8'h00) begin
                errors++;
                $display("FAIL bounce_toggle[%0d]: got st=%b a=%h, want st=00 a=00", i, state, a);
            end
        end
        btn = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (state !== 2'b00 || a !== 8'h00) begin
            errors++;
            $display("FAIL bounce_early: got st=%b a=%h, want st=00 a=00", state, a);
        end
        @(negedge clk);
        checks++;
        if (state !== 2'b01 || a !== 8'hA7) begin
            errors++;
            $display("FAIL bounce_capture: got st=%b a=%h, want st=01 a=a7", state, a);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (state !== 2'b01 || ops_valid !== 1'b0) begin
            errors++;
            $display("FAIL bounce_single: got st=%b ov=%b, want st=01 ov=0", state, ops_valid);
        end
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_short_pulse();
        @(negedge clk);
        sw  = 8'h55;
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (state !== 2'b01 || a !== 8'hA7 || b !== 8'h00) begin
            errors++;
            $display("FAIL short_pulse: got st=%b a=%h b=%h, want st=01 a=a7 b=00", state, a, b);
        end
    endtask

    task automatic test_sw_wiggle();
        logic [WIDTH-1:0] a0;
        logic [WIDTH-1:0] b0;
        logic [1:0]       s0;
        a0 = m_a;
        b0 = m_b;
        s0 = m_st;
        btn = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (a !== a0 || b !== b0 || state !== s0) begin
                errors++;
                $display("FAIL sw_wiggle[%0d]: got a=%h b=%h st=%b, want a=%h b=%h st=%b", i, a, b, state, a0, b0, s0);
            end
            sw = WIDTH'($urandom);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int hold;
            int use_clr;
            int clr_at;
            int clr_len;
            hold    = $urandom_range(1, 9);
            use_clr = ($urandom_range(0, 4) == 0) ? 1 : 0;
            clr_at  = $urandom_range(0, hold + 5);
            clr_len = $urandom_range(1, 2);
            for (int c = 0; c < hold + 12; c++) begin
                @(negedge clk);
                checks++;
                if ({a, b, ops_valid, new_pair, state} !== {m_a, m_b, m_ov, m_np, m_st}) begin
                    errors++;
                    $display("FAIL random[%0d.%0d]: got a=%h b=%h ov=%b np=%b st=%b, want a=%h b=%h ov=%b np=%b st=%b",
                             it, c, a, b, ops_valid, new_pair, state, m_a, m_b, m_ov, m_np, m_st);
                end
                sw  = WIDTH'($urandom);
                btn = (c < hold);
                clr = (use_clr != 0) && (c >= clr_at) && (c < clr_at + clr_len);
            end
        end
        clr = 1'b0;
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        do_press(8'h5A, 10);
        do_press(8'h3B, 10);
        checks++;
        if (a !== 8'h5A || ops_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrun_setup: got a=%h ov=%b, want a=5a ov=1", a, ops_valid);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a, b, ops_valid, new_pair, state} !== {8'h00, 8'h00, 1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL midrun_reset: got a=%h b=%h ov=%b np=%b st=%b, want all zero", a, b, ops_valid, new_pair, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_press(8'h77, 10);
        checks++;
        if ({a, b, ops_valid, new_pair, state} !== {m_a, m_b, m_ov, m_np, m_st}) begin
            errors++;
            $display("FAIL midrun_after: got a=%h st=%b, want a=%h st=%b", a, state, m_a, m_st);
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        btn   = 1'b0;
        clr   = 1'b0;
        sw    = '0;
        test_reset();
        test_pair_load();
        test_reload();
        test_clear_vs_press();
        test_bounce();
        test_short_pulse();
        test_sw_wiggle();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
